channel_display_ctrl: RTL and testbench

CHANNEL_DISPLAY_CTRL -- requirements
Module: channel_display_ctrl

---
 rtl/channel_display_pkg.sv | 58 +++++
 rtl/bin_to_7seg.sv | 13 +
 rtl/shift_display_driver.sv | 129 ++++++++++++
 rtl/channel_display_ctrl.sv | 120 ++++++++++++
 tb/tb_channel_display_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/channel_display_pkg.sv
// Shared display constants for the channel display: active-low segment
// codes (bit7=dp, bit6=g ... bit0=a), the channel glyph, blank code,
// the shift driver state encoding and small decode helpers.
package channel_display_pkg;

  localparam logic [7:0] SEG_BLANK    = 8'hFF;
  localparam logic [7:0] SEG_CH_GLYPH = 8'h86;

  localparam logic [7:0] SEG_D0 = 8'hC0;
  localparam logic [7:0] SEG_D1 = 8'hF9;
  localparam logic [7:0] SEG_D2 = 8'hA4;
  localparam logic [7:0] SEG_D3 = 8'hB0;
  localparam logic [7:0] SEG_D4 = 8'h99;
  localparam logic [7:0] SEG_D5 = 8'h92;
  localparam logic [7:0] SEG_D6 = 8'h82;
  localparam logic [7:0] SEG_D7 = 8'hF8;
  localparam logic [7:0] SEG_D8 = 8'h80;
  localparam logic [7:0] SEG_D9 = 8'h90;

  typedef enum logic [1:0] {
    DRV_IDLE = 2'd0,
    DRV_LOW  = 2'd1,
    DRV_HIGH = 2'd2
  } drv_state_t;

  // Decimal digit to segment code; anything above 9 shows blank.
  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Digit index to one-hot strobe.
  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bin_to_7seg.sv
// Combinational 4-bit to active-low 7-segment decoder; 10..15 blank.
module bin_to_7seg (
  input  logic [3:0] bin,
  output logic [7:0] seg
);
  import channel_display_pkg::*;

  // Table lookup of the segment pattern for one decimal digit
  always_comb begin
    seg = seg_of_digit(bin);
  end

endmodule

// File: rtl/shift_display_driver.sv
// Serialises one 8-bit segment pattern MSB first to an external shift
// register. Each bit is presented with sr_clk low for SR_HALF cycles,
// then sr_clk high for SR_HALF cycles, so busy lasts 16*SR_HALF cycles.
// The digit strobe is dark while shifting and lights the latched digit
// once the last bit has been clocked in.
module shift_display_driver #(
  parameter int SR_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_data,
  input  logic [1:0] digit_sel,
  input  logic       start,
  output logic       sr_clk,
  output logic       sr_data,
  output logic [3:0] digit_enable,
  output logic       busy
);
  import channel_display_pkg::*;

  localparam int HW = (SR_HALF > 1) ? $clog2(SR_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SR_HALF - 1);
  localparam logic [HW-1:0] HALF_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);

  drv_state_t    state_r, state_s;
  logic [HW-1:0] half_r, half_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shreg_r, shreg_s;
  logic [1:0]    sel_r, sel_s;
  logic          sr_clk_r, sr_clk_s;
  logic          sr_data_r, sr_data_s;
  logic [3:0]    de_r, de_s;
  logic          busy_r, busy_s;

  // Next-state and next-output logic of the serialiser FSM
  always_comb begin
    state_s   = state_r;
    half_s    = half_r;
    bit_s     = bit_r;
    shreg_s   = shreg_r;
    sel_s     = sel_r;
    sr_clk_s  = sr_clk_r;
    sr_data_s = sr_data_r;
    de_s      = de_r;
    busy_s    = busy_r;
    case (state_r)
      DRV_IDLE: begin
        if (start) begin
          state_s   = DRV_LOW;
          half_s    = HALF_ZERO;
          bit_s     = 3'd0;
          shreg_s   = seg_data;
          sel_s     = digit_sel;
          sr_clk_s  = 1'b0;
          sr_data_s = seg_data[7];
          de_s      = 4'b0000;
          busy_s    = 1'b1;
        end else begin
          state_s = DRV_IDLE;
        end
      end
      DRV_LOW: begin
        if (half_r == HALF_LAST) begin
          half_s   = HALF_ZERO;
          sr_clk_s = 1'b1;
          state_s  = DRV_HIGH;
        end else begin
          half_s = half_r + HALF_ONE;
        end
      end
      DRV_HIGH: begin
        if (half_r == HALF_LAST) begin
          half_s   = HALF_ZERO;
          sr_clk_s = 1'b0;
          if (bit_r == 3'd7) begin
            state_s = DRV_IDLE;
            busy_s  = 1'b0;
            de_s    = digit_onehot(sel_r);
          end else begin
            bit_s     = bit_r + 3'd1;
            shreg_s   = {shreg_r[6:0], 1'b0};
            sr_data_s = shreg_r[6];
            state_s   = DRV_LOW;
          end
        end else begin
          half_s = half_r + HALF_ONE;
        end
      end
      default: begin
        state_s  = DRV_IDLE;
        half_s   = HALF_ZERO;
        sr_clk_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= DRV_IDLE;
      half_r    <= HALF_ZERO;
      bit_r     <= 3'd0;
      shreg_r   <= SEG_BLANK;
      sel_r     <= 2'd0;
      sr_clk_r  <= 1'b0;
      sr_data_r <= 1'b0;
      de_r      <= 4'b0000;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      half_r    <= half_s;
      bit_r     <= bit_s;
      shreg_r   <= shreg_s;
      sel_r     <= sel_s;
      sr_clk_r  <= sr_clk_s;
      sr_data_r <= sr_data_s;
      de_r      <= de_s;
      busy_r    <= busy_s;
    end
  end

  assign sr_clk       = sr_clk_r;
  assign sr_data      = sr_data_r;
  assign digit_enable = de_r;
  assign busy         = busy_r;

endmodule

// File: rtl/channel_display_ctrl.sv
// Four-digit channel display controller. A refresh counter ticks once
// every MUX_MAX+1 cycles; each tick selects the next digit and, if the
// serialiser is free, hands it that digit's pattern (channel glyph,
// blank, tens, units -- or blank everywhere in standby).
module channel_display_ctrl #(
  parameter int MUX_MAX = 50000,
  parameter int SR_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic [6:0] canal,
  output logic       sr_clk,
  output logic       sr_data,
  output logic [3:0] digit_enable
);
  import channel_display_pkg::*;

  localparam int CW = (MUX_MAX > 0) ? $clog2(MUX_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUX_MAX);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    idx_r, idx_s;
  logic [7:0]    pattern_r, pattern_s;
  logic [1:0]    sel_r, sel_s;
  logic          start_r, start_s;
  logic          tick_s;
  logic          busy_s;
  logic [6:0]    tens_full_s;
  logic [3:0]    tens_s, units_s;
  logic [7:0]    tens_seg_s, units_seg_s, frame_seg_s;

  // Split the channel number into decimal tens and units
  always_comb begin
    tens_full_s = canal / 7'd10;
    tens_s      = 4'(tens_full_s % 7'd10);
    units_s     = 4'(canal % 7'd10);
  end

  bin_to_7seg u_tens_dec (
    .bin (tens_s),
    .seg (tens_seg_s)
  );

  bin_to_7seg u_units_dec (
    .bin (units_s),
    .seg (units_seg_s)
  );

  // Pattern for the digit currently selected by the refresh index
  always_comb begin
    if (power_on) begin
      case (idx_r)
        2'd0:    frame_seg_s = SEG_CH_GLYPH;
        2'd1:    frame_seg_s = SEG_BLANK;
        2'd2:    frame_seg_s = tens_seg_s;
        2'd3:    frame_seg_s = units_seg_s;
        default: frame_seg_s = SEG_BLANK;
      endcase
    end else begin
      frame_seg_s = SEG_BLANK;
    end
  end

  // Refresh tick, digit rotation and frame hand-off to the serialiser
  always_comb begin
    tick_s = (cnt_r == CNT_LAST);
    if (tick_s) begin
      cnt_s = CNT_ZERO;
      idx_s = idx_r + 2'd1;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
      idx_s = idx_r;
    end
    // start_r guards against re-issuing before the driver reports busy
    if (tick_s && !busy_s && !start_r) begin
      pattern_s = frame_seg_s;
      sel_s     = idx_r;
      start_s   = 1'b1;
    end else begin
      pattern_s = pattern_r;
      sel_s     = sel_r;
      start_s   = 1'b0;
    end
  end

  // Controller registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      idx_r     <= 2'd0;
      pattern_r <= SEG_BLANK;
      sel_r     <= 2'd0;
      start_r   <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      pattern_r <= pattern_s;
      sel_r     <= sel_s;
      start_r   <= start_s;
    end
  end

  shift_display_driver #(
    .SR_HALF (SR_HALF)
  ) u_driver (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_data     (pattern_r),
    .digit_sel    (sel_r),
    .start        (start_r),
    .sr_clk       (sr_clk),
    .sr_data      (sr_data),
    .digit_enable (digit_enable),
    .busy         (busy_s)
  );

endmodule

// File: tb/tb_channel_display_ctrl.sv
// Scoreboard bench for channel_display_ctrl: expected frames are queued
// as stimulus is applied and compared as the serial stream completes.
module tb_channel_display_ctrl;

  localparam int MUX_MAX = 40;
  localparam int SR_HALF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_on = 1'b0;
  logic [6:0] canal = 7'd1;
  logic       sr_clk;
  logic       sr_data;
  logic [3:0] digit_enable;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];
  int          idx_model = 0;

  int         frames_seen = 0;
  int         mon_bits = 0;
  int         zero_cnt = 0;
  bit         have_prev = 1'b0;
  logic [7:0] mon_shreg = 8'h00;
  logic       sr_clk_prev = 1'b0;
  logic [3:0] de_prev = 4'b0000;

  channel_display_ctrl #(
    .MUX_MAX (MUX_MAX),
    .SR_HALF (SR_HALF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .power_on     (power_on),
    .canal        (canal),
    .sr_clk       (sr_clk),
    .sr_data      (sr_data),
    .digit_enable (digit_enable)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int d);
    logic [7:0] s;
    case (d)
      0:       s = 8'hC0;
      1:       s = 8'hF9;
      2:       s = 8'hA4;
      3:       s = 8'hB0;
      4:       s = 8'h99;
      5:       s = 8'h92;
      6:       s = 8'h82;
      7:       s = 8'hF8;
      8:       s = 8'h80;
      9:       s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] ref_pattern(input int idx, input logic pwr, input int ch);
    logic [7:0] p;
    if (!pwr) begin
      p = 8'hFF;
    end else begin
      case (idx)
        0:       p = 8'h86;
        1:       p = 8'hFF;
        2:       p = ref_seg((ch / 10) % 10);
        3:       p = ref_seg(ch % 10);
        default: p = 8'hFF;
      endcase
    end
    return p;
  endfunction

  task automatic push_frames(input int n);
    logic [3:0] oh;
    for (int i = 0; i < n; i++) begin
      oh = 4'(1 << idx_model);
      exp_q.push_back({oh, ref_pattern(idx_model, power_on, int'(canal))});
      idx_model = (idx_model + 1) % 4;
    end
  endtask

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frames_seen + n;
    budget = n * (MUX_MAX + 1) + 200;
    while (frames_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("frame_timeout", 32'(frames_seen >= target), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_bits(input int k);
    int budget;
    budget = 200;
    while (mon_bits < k && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("bits_timeout", 32'(mon_bits >= k), 32'd1);
  endtask

  // Frame monitor: collects bits on sr_clk rises, scores each completed frame
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits    <= 0;
      zero_cnt    <= 0;
      have_prev   <= 1'b0;
      sr_clk_prev <= 1'b0;
      de_prev     <= 4'b0000;
      mon_shreg   <= 8'h00;
    end else begin
      if (sr_clk && !sr_clk_prev) begin
        mon_shreg <= {mon_shreg[6:0], sr_data};
        mon_bits  <= mon_bits + 1;
        check_eq("de_dark_while_shifting", 32'(digit_enable), 32'd0);
      end
      if (digit_enable != 4'b0000 && de_prev == 4'b0000) begin
        check_eq("sr_clk_edges_per_frame", 32'(mon_bits), 32'd8);
        check_eq("sr_clk_low_after_frame", 32'(sr_clk), 32'd0);
        if (have_prev) begin
          check_eq("busy_cycles", 32'(zero_cnt), 32'(16 * SR_HALF));
        end
        if (exp_q.size() == 0) begin
          check_eq("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          check_eq("frame_pattern", 32'(mon_shreg), 32'(exp_q[0][7:0]));
          check_eq("frame_digit", 32'(digit_enable), 32'(exp_q[0][11:8]));
          exp_q.delete(0);
        end
        have_prev   <= 1'b1;
        mon_bits    <= 0;
        frames_seen <= frames_seen + 1;
      end
      zero_cnt    <= (digit_enable == 4'b0000) ? zero_cnt + 1 : 0;
      sr_clk_prev <= sr_clk;
      de_prev     <= digit_enable;
    end
  end

  initial begin
    // Reset state in standby, channel 1
    repeat (3) @(negedge clk);
    check_eq("rst_sr_clk", 32'(sr_clk), 32'd0);
    check_eq("rst_sr_data", 32'(sr_data), 32'd0);
    check_eq("rst_digit_enable", 32'(digit_enable), 32'd0);
    rst_n = 1'b1;
    idx_model = 0;
    push_frames(4);
    wait_frames(4);

    // Channel 42
    power_on = 1'b1;
    canal = 7'd42;
    push_frames(4);
    wait_frames(4);

    // Channel 64 then 07 at the wrap
    canal = 7'd64;
    push_frames(4);
    wait_frames(4);
    canal = 7'd7;
    push_frames(4);
    wait_frames(4);

    // Range boundaries: 0 and 127
    canal = 7'd0;
    push_frames(4);
    wait_frames(4);
    canal = 7'd127;
    push_frames(4);
    wait_frames(4);

    // Inputs changed mid-shift must not disturb the frame in progress
    canal = 7'd25;
    push_frames(3);
    wait_frames(2);
    wait_bits(2);
    canal = 7'd99;
    power_on = 1'b0;
    wait_frames(1);
    push_frames(1);
    wait_frames(1);

    // Reset in the middle of a frame
    power_on = 1'b1;
    canal = 7'd42;
    push_frames(1);
    wait_bits(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_sr_clk", 32'(sr_clk), 32'd0);
    check_eq("midrst_sr_data", 32'(sr_data), 32'd0);
    check_eq("midrst_digit_enable", 32'(digit_enable), 32'd0);
    exp_q.delete();
    idx_model = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_frames(4);
    wait_frames(4);

    // Sweep every nominal channel
    for (int ch = 1; ch <= 64; ch++) begin
      canal = 7'(ch);
      push_frames(4);
      wait_frames(4);
    end

    // Standby: all blank
    power_on = 1'b0;
    push_frames(4);
    wait_frames(4);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
